// File: rtl/mult_seq_nxn.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Handles unsigned and two's-complement signed operands by multiplying
// magnitudes and negating the result when the operand signs differ.
// Start/busy/done handshake; ovf flags a product that does not fit in WIDTH bits.
module mult_seq_nxn #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            sgn;
  logic            neg;

  logic            accept;
  logic            last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   result;
  logic            ovf_next;

  // A new operation is taken whenever the unit is not mid-calculation.
  assign accept = start && (state != CALC);
  assign last   = (state == CALC) && (cnt == LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> CALC on start, CALC for WIDTH cycles, DONE for one cycle.
  // NOTE: the default assignment up front keeps this block from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == LAST) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state.
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // Datapath arithmetic: operand magnitudes, partial-product add, final sign and overflow.
  always_comb begin
    a_mag    = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag    = (signed_mode && b[WIDTH-1]) ? -b : b;
    acc_sum  = acc + (mplier[0] ? mcand : '0);
    // Negating zero yields zero, so a zero product never picks up a sign.
    result   = (sgn && neg) ? -acc_sum : acc_sum;
    if (sgn) ovf_next = !((&result[PW-1:WIDTH-1]) || !(|result[PW-1:WIDTH-1]));
    else     ovf_next = |result[PW-1:WIDTH];
  end

  // Datapath registers: capture on accept, one multiplier bit per CALC cycle,
  // result and flag loaded on the final CALC edge (entry to DONE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      neg    <= 1'b0;
      p      <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        cnt    <= '0;
        sgn    <= signed_mode;
        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state == CALC) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (last) begin
        p   <= result;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Self-checking bench for mult_seq_nxn: directed and random operations at
// WIDTH=8, random sweeps at WIDTH=4 and WIDTH=16. Expected results come from
// an arithmetic reference model and are queued at issue time; monitors pop
// and compare whenever done is seen.
module tb_mult_seq_nxn;

  typedef struct {
    logic [31:0] p;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_r;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full-precision integer product, reduced to 2*w bits; overflow
  // when the mathematical product lies outside the w-bit range of the mode.
  function automatic logic [32:0] ref_mul(int w, bit s, logic [15:0] x, logic [15:0] y);
    longint xv, yv, pr;
    logic [63:0] pm;
    logic o;
    xv = longint'(x);
    yv = longint'(y);
    if (s && x[w-1]) xv -= longint'(1) << w;
    if (s && y[w-1]) yv -= longint'(1) << w;
    pr = xv * yv;
    if (s) o = (pr < -(longint'(1) << (w - 1))) || (pr >= (longint'(1) << (w - 1)));
    else   o = pr >= (longint'(1) << w);
    pm = pr;
    pm = pm & ((64'd1 << (2 * w)) - 64'd1);
    return {o, pm[31:0]};
  endfunction

  // ---------------- WIDTH = 8 instance: directed + random ----------------
  logic        start8, sm8, busy8, done8, ovf8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  exp_t        q8[$];
  int          cyc8 = 0;
  logic [15:0] last_p8;
  logic        last_ovf8;

  mult_seq_nxn #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8), .ovf(ovf8)
  );

  always @(posedge clk) cyc8++;

  // Monitor: compare on done, otherwise the held result must not move.
  always @(negedge clk) begin
    if (rst) begin
      last_p8   = '0;
      last_ovf8 = 1'b0;
    end else if (done8) begin
      check("w8_busy_in_done", busy8, 0);
      if (q8.size() == 0) check("w8_done_without_start", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_p", p8, e.p);
        check("w8_ovf", ovf8, e.ovf);
        check("w8_latency", cyc8 - e.cyc, 9);
      end
      last_p8   = p8;
      last_ovf8 = ovf8;
    end else begin
      check("w8_p_hold", p8, last_p8);
      check("w8_ovf_hold", ovf8, last_ovf8);
    end
  end

  // Drive a start request now; queue the expected result if it will be accepted.
  task automatic go8(bit s, logic [7:0] x, logic [7:0] y, logic [15:0] ep, bit eo);
    sm8 = s; a8 = x; b8 = y; start8 = 1'b1;
    if (!busy8 && !rst) q8.push_back('{p: 32'(ep), ovf: eo, cyc: cyc8});
  endtask

  task automatic wait_idle8;
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #1;
      if (!busy8 && q8.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("w8_idle_timeout", 1, 0);
  endtask

  task automatic op8(bit s, logic [7:0] x, logic [7:0] y, logic [15:0] ep, bit eo);
    wait_idle8;
    go8(s, x, y, ep, eo);
    @(negedge clk); #1 start8 = 1'b0;
  endtask

  task automatic op8m(bit s, logic [7:0] x, logic [7:0] y);
    logic [32:0] r;
    r = ref_mul(8, s, 16'(x), 16'(y));
    op8(s, x, y, r[15:0], r[32]);
  endtask

  // ---------------- WIDTH = 4 and 16 instances: random sweep ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_rand
    localparam int W = (gi == 0) ? 4 : 16;
    logic           start_r, sm_r, busy_r, done_r, ovf_r;
    logic [W-1:0]   a_r, b_r;
    logic [2*W-1:0] p_r;
    logic [2*W-1:0] last_p;
    logic           last_ovf;
    exp_t           q[$];
    int             cyc = 0;
    bit             fin = 1'b0;

    mult_seq_nxn #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst_r), .start(start_r), .signed_mode(sm_r),
      .a(a_r), .b(b_r), .busy(busy_r), .done(done_r), .p(p_r), .ovf(ovf_r)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
      if (rst_r) begin
        last_p   = '0;
        last_ovf = 1'b0;
      end else if (done_r) begin
        if (q.size() == 0) check("rnd_done_without_start", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("rnd_p", 32'(p_r), e.p);
          check("rnd_ovf", ovf_r, e.ovf);
          check("rnd_latency", cyc - e.cyc, W + 1);
        end
        last_p   = p_r;
        last_ovf = ovf_r;
      end else begin
        check("rnd_p_hold", 32'(p_r), 32'(last_p));
      end
    end

    initial begin
      logic [32:0] r;
      start_r = 1'b0; sm_r = 1'b0; a_r = '0; b_r = '0;
      wait (rst_r === 1'b0);
      for (int i = 0; i < 600; i++) begin
        @(negedge clk); #1;
        start_r = ($urandom % 3) == 0;
        sm_r    = $urandom;
        a_r     = W'($urandom);
        b_r     = W'($urandom);
        if (start_r && !busy_r) begin
          r = ref_mul(W, sm_r, 16'(a_r), 16'(b_r));
          q.push_back('{p: r[31:0], ovf: r[32], cyc: cyc});
        end
      end
      @(negedge clk); #1 start_r = 1'b0;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) check("rnd_drain_timeout", 1, 0);
      fin = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    rst = 1'b1; rst_r = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_p", p8, 0);
    check("reset_ovf", ovf8, 0);
    #1 rst = 1'b0; rst_r = 1'b0;

    // Unsigned directed cases.
    op8(0, 8'd13,  8'd11,  16'h008F, 0);
    op8(0, 8'd16,  8'd16,  16'h0100, 1);
    op8(0, 8'd255, 8'd255, 16'hFE01, 1);
    op8(0, 8'd0,   8'd200, 16'h0000, 0);
    // Signed directed cases.
    op8(1, 8'hFD, 8'h05, 16'hFFF1, 0);
    op8(1, 8'h80, 8'h80, 16'h4000, 1);
    op8(1, 8'h80, 8'h01, 16'hFF80, 0);

    // start during CALC with changing operands is ignored.
    op8m(0, 8'd200, 8'd3);
    for (int i = 0; i < 20; i++) begin
      if (busy8) begin
        start8 = 1'b1; sm8 = $urandom; a8 = $urandom; b8 = $urandom;
      end else begin
        start8 = 1'b0;
        break;
      end
      @(negedge clk); #1;
    end
    start8 = 1'b0;

    // Back-to-back: start asserted in the DONE cycle.
    op8m(1, 8'h7F, 8'h02);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (done8) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("w8_done_timeout", 1, 0);
    begin
      logic [32:0] r;
      r = ref_mul(8, 1, 16'hF0, 16'h10);
      go8(1, 8'hF0, 8'h10, r[15:0], r[32]);
    end
    @(negedge clk); #1 start8 = 1'b0;

    // Asynchronous reset in CALC cycle 4 aborts with no done.
    wait_idle8;
    go8(0, 8'd99, 8'd77, 16'(99 * 77), 1);
    @(negedge clk); #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", busy8, 0);
    check("async_rst_done", done8, 0);
    check("async_rst_p", p8, 0);
    check("async_rst_ovf", ovf8, 0);
    q8.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    op8(0, 8'd99, 8'd77, 16'd7623, 1);

    // Random sweep at WIDTH=8, including starts while busy and in DONE.
    wait_idle8;
    for (int i = 0; i < 500; i++) begin
      if (($urandom % 3) == 0) begin
        logic [32:0] r;
        logic [7:0]  x, y;
        bit          s;
        s = $urandom; x = $urandom; y = $urandom;
        r = ref_mul(8, s, 16'(x), 16'(y));
        go8(s, x, y, r[15:0], r[32]);
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk); #1;
    end
    start8 = 1'b0;
    wait_idle8;

    begin
      bit all_fin = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if (g_rand[0].fin && g_rand[1].fin) begin
          all_fin = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!all_fin) check("rnd_sweep_timeout", 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
